apb_master: RTL and testbench
=============================

# apb_master

APB initiator that turns single-beat command requests into APB SETUP/ACCESS transfers on the 8-bit-address, 8-bit-data bus used by the I2C-APB subsystem. Its responder is the FIFO-bridge slave: TX byte writes go to address 0x00 and RX byte reads come from address 0x04. A PREADY wait counter can terminate stalled transfers. The block sits between a host-side controller or sequencer and the I2C register/FIFO bridge.

## Interface
- TIMEOUT, 16: maximum ACCESS cycles without PREADY before abort; legal range 1..255; used only with timeout compiled in.
- PCLK  input  1  clock; all logic on rising edge.
- PRESET  input  1  synchronous, active-high reset.
- CMD_VALID  input  1  command request.
- CMD_READY  output  1  command accepted on the edge where CMD_VALID and CMD_READY are both 1.
- CMD_WRITE  input  1  1 = write, 0 = read.
- CMD_ADDR  input  8  transfer address.
- CMD_WDATA  input  8  write data.
- RSP_VALID  output  1  one-cycle completion pulse.
- RSP_RDATA  output  8  read data; valid with RSP_VALID.
- RSP_ERR  output  1  timeout flag; valid with RSP_VALID.
- BUSY  output  1  1 when state is not IDLE.
- PSELx  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  8  APB address.
- PWDATA  output  8  APB write data.
- PREADY  input  1  slave completion.
- PRDATA  input  8  slave read data.

## Operation
- FSM states:
  - IDLE: PSELx=0, PENABLE=0, CMD_READY=1.
  - SETUP: PSELx=1, PENABLE=0, CMD_READY=0.
  - ACCESS: PSELx=1, PENABLE=1, CMD_READY=0.
- Transitions:
  - IDLE→SETUP on command accept. CMD_WRITE, CMD_ADDR and CMD_WDATA are registered into PWRITE, PADDR and PWDATA on that same edge.
  - SETUP→ACCESS unconditionally.
  - ACCESS→IDLE on the edge with PREADY=1, or on timeout.
  - ACCESS→ACCESS otherwise.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. They hold their last values in IDLE and change only on command accept.
- Completion with PREADY=1:
  - RSP_VALID=1 for exactly one cycle, RSP_ERR=0.
  - Read: RSP_RDATA = PRDATA sampled on the completing edge.
  - Write: RSP_RDATA = 0x00.
- RSP_RDATA and RSP_ERR hold until the next completion.
- Wait counter: 8 bits, cleared on entry to ACCESS, incremented on each ACCESS edge with PREADY=0. It does not wrap, because TIMEOUT ≤ 255 bounds it.
- Only one outstanding transfer. No command is accepted while BUSY=1, and CMD_VALID is ignored outside IDLE.
- Reset values (PRESET=1 on an edge): state IDLE; PSELx, PENABLE, PWRITE, RSP_VALID, RSP_ERR = 0; PADDR, PWDATA, RSP_RDATA = 0x00; counter 0; BUSY=0; CMD_READY=1 on the cycle after reset.
- Reset mid-transfer: return to IDLE on that edge. No RSP_VALID is generated for the aborted transfer.
- PRESET overrides a simultaneous command accept or PREADY.

## Timing
- Accept edge at T0:
  - T0→T1: SETUP cycle.
  - T1→T2: first ACCESS cycle.
  - Zero-wait completion at the edge ending T2. RSP_VALID is high during T3, alongside IDLE.
- Minimum cost is 3 cycles per transfer. The earliest next accept is at the end of T3, so PSELx is low for at least one cycle between transfers.
- Each PREADY=0 cycle in ACCESS adds one cycle of latency.
- RSP_VALID rises on the same edge that PSELx falls.
- PRDATA is sampled only when PREADY=1 in ACCESS; PRDATA in other cycles is don't-care.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - If PREADY is still 0 on the TIMEOUT-th ACCESS edge, the transfer terminates: RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0x00, state IDLE.
  - ACCESS therefore lasts at most TIMEOUT cycles.
  - PREADY=1 on that same edge counts as a normal completion, not a timeout.
- Undefined: no counter logic; ACCESS waits indefinitely for PREADY; RSP_ERR is tied to 0.

## Test plan
- Write with zero waits: CMD ADDR=0x00, WDATA=0xA5, PREADY=1 in ACCESS → PSELx high 2 cycles, PENABLE high 1 cycle, PADDR=0x00, PWDATA=0xA5; RSP_VALID one cycle, RSP_ERR=0, RSP_RDATA=0x00.
- Read with 3 wait states: ADDR=0x04, PREADY low 3 ACCESS cycles then high with PRDATA=0x3C → ACCESS lasts 4 cycles, RSP_RDATA=0x3C, RSP_ERR=0.
- Timeout (macro on, TIMEOUT=4): read with PREADY held 0 → exactly 4 ACCESS cycles, then RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0x00, BUSY=0. With the macro off, the bench stays in ACCESS for 100 cycles with no RSP_VALID.
- Back-to-back: CMD_VALID held high with two commands (write 0x11, read) → CMD_READY low while BUSY; second accept one cycle after the first RSP_VALID edge; PSELx low ≥1 cycle between transfers; PADDR stable through each transfer.
- Reset mid-ACCESS: PRESET=1 for one edge during wait states → next cycle PSELx=0, PENABLE=0, all outputs at reset values, no RSP_VALID; a subsequent command completes normally.

Source files
------------

// File: rtl/apb_master_if.sv
// Bus bundle for apb_master: the host-side command/response handshake
// and the APB signals towards the FIFO-bridge responder.
// The master modport is the initiator's view. The slave modport is the
// view of everything around it: the host plus the APB responder.
interface apb_master_if;
  // host command channel
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       CMD_WRITE;
  logic [7:0] CMD_ADDR;
  logic [7:0] CMD_WDATA;
  // host response channel
  logic       RSP_VALID;
  logic [7:0] RSP_RDATA;
  logic       RSP_ERR;
  logic       BUSY;
  // APB bus
  logic       PSELx;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic       PREADY;
  logic [7:0] PRDATA;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, PREADY, PRDATA,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, PREADY, PRDATA,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator on the 8-bit I2C-APB bus.
// Each accepted command becomes one SETUP + ACCESS transfer, and the
// result comes back as a one-cycle RSP_VALID pulse.
// Optional feature macro: APB_MASTER_TIMEOUT_EN. When it is defined, an
// ACCESS phase that sees no PREADY for TIMEOUT edges is aborted with
// RSP_ERR=1. When it is undefined, ACCESS waits for PREADY indefinitely.
module apb_master #(
  parameter int TIMEOUT = 16
) (
  input logic          PCLK,
  input logic          PRESET,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   done_ok;
  logic   done_to;

  // An illegal TIMEOUT is caught while the design is elaborated.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT must be in 1..255");
  end

  assign accept  = (state == IDLE) && bus.CMD_VALID;
  assign done_ok = (state == ACCESS) && bus.PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;
  logic       rsp_err_q;

  // Abort when the TIMEOUT-th ACCESS edge also arrives without PREADY.
  assign done_to = (state == ACCESS) && !bus.PREADY && (wait_cnt == TIMEOUT_LAST);

  // Count ACCESS edges without PREADY. The count restarts while in SETUP.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt <= 8'd0;
    end else if (state == SETUP) begin
      wait_cnt <= 8'd0;
    end else if (state == ACCESS && !bus.PREADY) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // The error flag is set by a timeout, cleared by a normal completion,
  // and held between completions.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_err_q <= 1'b0;
    end else if (done_ok) begin
      rsp_err_q <= 1'b0;
    end else if (done_to) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign bus.RSP_ERR = rsp_err_q;
`else
  assign done_to     = 1'b0;
  assign bus.RSP_ERR = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> SETUP -> ACCESS -> (wait)* -> IDLE.
  // NOTE: each always_comb assigns its default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done_ok || done_to) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus control and handshake outputs are decoded from the state alone.
  always_comb begin
    bus.PSELx     = 1'b0;
    bus.PENABLE   = 1'b0;
    bus.CMD_READY = 1'b0;
    bus.BUSY      = (state != IDLE);
    case (state)
      IDLE:    bus.CMD_READY = 1'b1;
      SETUP:   bus.PSELx     = 1'b1;
      ACCESS: begin
        bus.PSELx   = 1'b1;
        bus.PENABLE = 1'b1;
      end
      default: bus.CMD_READY = 1'b0;
    endcase
  end

  // Capture the address phase on accept and the response on completion.
  // NOTE: these are plain flops, not a memory, so every one of them is
  // reset and no X can escape onto the bus after PRESET.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= 8'h00;
      bus.PWDATA    <= 8'h00;
      bus.RSP_VALID <= 1'b0;
      bus.RSP_RDATA <= 8'h00;
    end else begin
      bus.RSP_VALID <= done_ok || done_to;
      if (accept) begin
        bus.PWRITE <= bus.CMD_WRITE;
        bus.PADDR  <= bus.CMD_ADDR;
        bus.PWDATA <= bus.CMD_WDATA;
      end
      if (done_ok) begin
        bus.RSP_RDATA <= bus.PWRITE ? 8'h00 : bus.PRDATA;
      end else if (done_to) begin
        bus.RSP_RDATA <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master. It uses a vector table, hand-written
// corner sequences and randomized transfers checked against a transfer-level
// model. Build with +define+APB_MASTER_TIMEOUT_EN to cover the timeout build.
module tb_apb_master;

  localparam int TB_TIMEOUT = 4;

  logic PCLK = 1'b0;
  logic PRESET;

  apb_master_if bus ();

  apb_master #(.TIMEOUT(TB_TIMEOUT)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] last_rdata;

  typedef struct {
    logic       w;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] prdata;
    int         exp_access;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CMD_VALID = 1'b0;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_ADDR  = 8'h00;
    bus.CMD_WDATA = 8'h00;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = 8'h00;
  endtask

  // Transfer-level model: outcome of one command given its wait states.
  function automatic void model(input logic w, input int waits, input logic [7:0] prd,
                                output int acc, output logic [7:0] rd, output logic err);
    acc = waits + 1;
    err = 1'b0;
    rd  = w ? 8'h00 : prd;
`ifdef APB_MASTER_TIMEOUT_EN
    if (waits >= TB_TIMEOUT) begin
      acc = TB_TIMEOUT;
      err = 1'b1;
      rd  = 8'h00;
    end
`endif
  endfunction

  // Issue one command from IDLE and play the responder: PREADY stays low
  // for 'waits' ACCESS cycles. Returns what was observed. The run stops
  // after max_cycles cycles without a response.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input int waits, input logic [7:0] prd, input int max_cycles,
                      output int setup_n, output int access_n,
                      output logic [7:0] rdata, output logic err, output logic ok);
    setup_n  = 0;
    access_n = 0;
    rdata    = 8'h00;
    err      = 1'b0;
    ok       = 1'b0;
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = w;
    bus.CMD_ADDR  = a;
    bus.CMD_WDATA = d;
    bus.PREADY    = 1'b0;
    step();
    // Garbage on the command port must not disturb the transfer.
    bus.CMD_VALID = 1'b0;
    bus.CMD_WRITE = 1'($urandom);
    bus.CMD_ADDR  = 8'($urandom);
    bus.CMD_WDATA = 8'($urandom);
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      if (bus.RSP_VALID) begin
        ok    = 1'b1;
        rdata = bus.RSP_RDATA;
        err   = bus.RSP_ERR;
        break;
      end
      if (bus.BUSY) check("cmd_ready_while_busy", 16'(bus.CMD_READY), 16'd0);
      if (bus.PSELx && !bus.PENABLE) begin
        setup_n++;
        bus.PREADY = 1'($urandom);
        bus.PRDATA = 8'($urandom);
      end else if (bus.PSELx && bus.PENABLE) begin
        access_n++;
        check("paddr_stable", 16'(bus.PADDR), 16'(a));
        check("pwrite_stable", 16'(bus.PWRITE), 16'(w));
        if (w) check("pwdata_stable", 16'(bus.PWDATA), 16'(d));
        bus.PREADY = (access_n > waits);
        bus.PRDATA = bus.PREADY ? prd : 8'($urandom);
      end
      step();
    end
    bus.PREADY = 1'b0;
  endtask

  // Run one command and compare everything against the expected outcome.
  task automatic run_and_check(input logic w, input logic [7:0] a, input logic [7:0] d,
                               input int waits, input logic [7:0] prd,
                               input int exp_acc, input logic [7:0] exp_rd, input logic exp_err);
    int         s_n;
    int         a_n;
    logic [7:0] rd;
    logic       er;
    logic       ok;
    xfer(w, a, d, waits, prd, 300, s_n, a_n, rd, er, ok);
    check("rsp_seen", 16'(ok), 16'd1);
    check("setup_cycles", 16'(s_n), 16'd1);
    check("access_cycles", 16'(a_n), 16'(exp_acc));
    check("rsp_rdata", 16'(rd), 16'(exp_rd));
    check("rsp_err", 16'(er), 16'(exp_err));
    check("psel_low_at_rsp", 16'(bus.PSELx), 16'd0);
    check("busy_low_at_rsp", 16'(bus.BUSY), 16'd0);
    last_rdata = exp_rd;
    step();
    check("rsp_one_cycle", 16'(bus.RSP_VALID), 16'd0);
    check("rdata_hold", 16'(bus.RSP_RDATA), 16'(last_rdata));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_psel"}, 16'(bus.PSELx), 16'd0);
    check({tag, "_penable"}, 16'(bus.PENABLE), 16'd0);
    check({tag, "_pwrite"}, 16'(bus.PWRITE), 16'd0);
    check({tag, "_paddr"}, 16'(bus.PADDR), 16'd0);
    check({tag, "_pwdata"}, 16'(bus.PWDATA), 16'd0);
    check({tag, "_rsp_valid"}, 16'(bus.RSP_VALID), 16'd0);
    check({tag, "_rsp_err"}, 16'(bus.RSP_ERR), 16'd0);
    check({tag, "_rsp_rdata"}, 16'(bus.RSP_RDATA), 16'd0);
    check({tag, "_busy"}, 16'(bus.BUSY), 16'd0);
    check({tag, "_cmd_ready"}, 16'(bus.CMD_READY), 16'd1);
  endtask

  // Hard stop in case a wait is ever left unbounded.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{1'b1, 8'h00, 8'hA5, 0, 8'h00, 1, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h04, 8'h00, 3, 8'h3C, 4, 8'h3C, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 1, 8'h99, 2, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 8'h04, 8'h00, 0, 8'hC3, 1, 8'hC3, 1'b0};
    vecs[4] = '{1'b0, 8'h04, 8'h00, 2, 8'h00, 3, 8'h00, 1'b0};

    // Reset, with a command offered at the same time: reset must win.
    idle_inputs();
    bus.CMD_VALID = 1'b1;
    bus.CMD_ADDR  = 8'h04;
    PRESET = 1'b1;
    step();
    step();
    check("reset_accept_blocked_busy", 16'(bus.BUSY), 16'd0);
    PRESET = 1'b0;
    bus.CMD_VALID = 1'b0;
    check_reset_values("reset");
    last_rdata = 8'h00;
    step();

    // Table-driven transfers.
    foreach (vecs[i]) begin
      run_and_check(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].prdata,
                    vecs[i].exp_access, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Back-to-back: CMD_VALID held high across two commands.
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = 1'b1;
    bus.CMD_ADDR  = 8'h00;
    bus.CMD_WDATA = 8'h11;
    bus.PREADY    = 1'b0;
    step();
    check("b2b_setup_psel", 16'(bus.PSELx), 16'd1);
    check("b2b_setup_ready", 16'(bus.CMD_READY), 16'd0);
    check("b2b_setup_pwdata", 16'(bus.PWDATA), 16'h11);
    bus.CMD_WRITE = 1'b0;
    bus.CMD_ADDR  = 8'h04;
    bus.CMD_WDATA = 8'h77;
    step();
    check("b2b_access_penable", 16'(bus.PENABLE), 16'd1);
    check("b2b_access_ready", 16'(bus.CMD_READY), 16'd0);
    check("b2b_access_paddr", 16'(bus.PADDR), 16'h00);
    bus.PREADY = 1'b1;
    step();
    bus.PREADY = 1'b0;
    check("b2b_rsp1_valid", 16'(bus.RSP_VALID), 16'd1);
    check("b2b_rsp1_psel", 16'(bus.PSELx), 16'd0);
    check("b2b_rsp1_ready", 16'(bus.CMD_READY), 16'd1);
    check("b2b_rsp1_rdata", 16'(bus.RSP_RDATA), 16'h00);
    check("b2b_rsp1_paddr_hold", 16'(bus.PADDR), 16'h00);
    step();
    bus.CMD_VALID = 1'b0;
    check("b2b_accept2_psel", 16'(bus.PSELx), 16'd1);
    check("b2b_accept2_penable", 16'(bus.PENABLE), 16'd0);
    check("b2b_accept2_paddr", 16'(bus.PADDR), 16'h04);
    check("b2b_accept2_pwrite", 16'(bus.PWRITE), 16'd0);
    step();
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h5A;
    step();
    bus.PREADY = 1'b0;
    check("b2b_rsp2_valid", 16'(bus.RSP_VALID), 16'd1);
    check("b2b_rsp2_rdata", 16'(bus.RSP_RDATA), 16'h5A);
    check("b2b_rsp2_err", 16'(bus.RSP_ERR), 16'd0);
    step();
    check("b2b_rsp2_one_cycle", 16'(bus.RSP_VALID), 16'd0);

    // Reset during ACCESS wait states.
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_ADDR  = 8'h04;
    step();
    bus.CMD_VALID = 1'b0;
    step();
    step();
    check("midrst_in_access", 16'(bus.PENABLE), 16'd1);
    bus.PREADY = 1'b1;
    PRESET     = 1'b1;
    step();
    PRESET     = 1'b0;
    bus.PREADY = 1'b0;
    check_reset_values("midrst");
    last_rdata = 8'h00;
    step();
    check("midrst_no_late_rsp", 16'(bus.RSP_VALID), 16'd0);
    run_and_check(1'b1, 8'h00, 8'h42, 1, 8'h00, 2, 8'h00, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout: PREADY never rises, so ACCESS lasts exactly TIMEOUT cycles.
    run_and_check(1'b0, 8'h04, 8'h00, 1000, 8'hEE, TB_TIMEOUT, 8'h00, 1'b1);
    check("timeout_err_hold", 16'(bus.RSP_ERR), 16'd1);
    run_and_check(1'b0, 8'h04, 8'h00, 0, 8'h81, 1, 8'h81, 1'b0);
`else
    // Without the timeout, ACCESS keeps waiting for PREADY.
    begin
      int         s_n;
      int         a_n;
      logic [7:0] rd;
      logic       er;
      logic       ok;
      xfer(1'b0, 8'h04, 8'h00, 1000, 8'hEE, 101, s_n, a_n, rd, er, ok);
      check("notimeout_no_rsp", 16'(ok), 16'd0);
      check("notimeout_access_cycles", 16'(a_n), 16'd100);
      check("notimeout_still_busy", 16'(bus.BUSY), 16'd1);
      check("notimeout_err_zero", 16'(bus.RSP_ERR), 16'd0);
      PRESET = 1'b1;
      step();
      PRESET = 1'b0;
      check("notimeout_recover_idle", 16'(bus.BUSY), 16'd0);
      last_rdata = 8'h00;
    end
`endif

    // Randomized transfers against the model, with idle gaps between them.
    for (int n = 0; n < 40; n++) begin
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] prd;
      int         waits;
      int         acc;
      logic [7:0] rd;
      logic       er;
      w     = 1'($urandom);
      a     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (w ? 8'h00 : 8'h04);
      d     = 8'($urandom);
      prd   = 8'($urandom);
      waits = $urandom_range(0, 6);
      model(w, waits, prd, acc, rd, er);
      run_and_check(w, a, d, waits, prd, acc, rd, er);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        bus.PRDATA = 8'($urandom);
        step();
        check("gap_rsp_valid", 16'(bus.RSP_VALID), 16'd0);
        check("gap_rdata_hold", 16'(bus.RSP_RDATA), 16'(last_rdata));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
